sha1_msg_sequencer: RTL and testbench

//  Streams an arbitrary-length message as 32-bit words, applies SHA-1 padding, and packs 512-bit blocks.

---
 rtl/sha1_pkg.sv | 18 +
 rtl/sha1_block_buffer.sv | 44 ++++
 rtl/sha1_msg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_sha1_msg_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants, FSM state and buffer write-select encodings for the SHA-1 message sequencer.
package sha1_pkg;
    localparam int WORD_W    = 32;
    localparam int BLK_W     = 512;
    localparam int HASH_W    = 160;
    localparam int BLK_WORDS = 16;
    localparam logic [HASH_W-1:0] SHA1_IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, WAIT, FIN} state_e;
    typedef enum logic [2:0] {WR_DATA, WR_MERGE, WR_PAD80, WR_ZERO, WR_LEN_HI, WR_LEN_LO} wr_sel_e;

    // Keeps the first n bytes and appends the 0x80 marker; n=4 returns the word untouched.
    function automatic logic [WORD_W-1:0] pad_merge(input logic [WORD_W-1:0] data, input logic [2:0] n);
        logic [5:0] sh;
        sh = {n, 3'b000};
        return (data & ~(32'hffff_ffff >> sh)) | (32'h8000_0000 >> sh);
    endfunction
endpackage

// File: rtl/sha1_block_buffer.sv
// sha1_block_buffer: 16x32 block buffer with pad-byte merge, zero/length word insertion and whole-block length load.
module sha1_block_buffer
    import sha1_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [3:0]         wr_idx,
    input  wr_sel_e            wr_sel,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [2:0]         wr_nbytes,
    input  logic               len_ld,
    input  logic [63:0]        len,
    output logic [BLK_W-1:0]   blk
);
    // Word 0 lives in the top slice so the packed array is already the block layout.
    logic [BLK_WORDS-1:0][WORD_W-1:0] mem_q, mem_d;
    logic [WORD_W-1:0] word;

    always_comb begin
        case (wr_sel)
            WR_DATA:   word = wr_data;
            WR_MERGE:  word = pad_merge(wr_data, wr_nbytes);
            WR_PAD80:  word = 32'h8000_0000;
            WR_LEN_HI: word = len[63:32];
            WR_LEN_LO: word = len[31:0];
            default:   word = '0;
        endcase
        mem_d = mem_q;
        if (len_ld)
            mem_d = {448'h0, len};
        else if (wr_en)
            mem_d[4'd15 - wr_idx] = word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_q <= '0;
        else
            mem_q <= mem_d;
    end

    assign blk = mem_q;
endmodule

// File: rtl/sha1_msg_sequencer.sv
// sha1_msg_sequencer: pads a 32-bit word message stream into SHA-1 blocks, sequences the
// compression core one block at a time, chains H0..H4 and presents the final digest.
module sha1_msg_sequencer
    import sha1_pkg::*;
#(
    parameter int                LEN_W = 64,
    parameter logic [HASH_W-1:0] IV    = SHA1_IV
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [2:0]         in_nbytes,
    output logic               blk_start,
    output logic [BLK_W-1:0]   blk,
    output logic [HASH_W-1:0]  h_in,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  h_out,
    output logic [HASH_W-1:0]  digest,
    output logic               digest_valid,
    output logic               busy
);
    state_e state_q, state_d, next_q, next_d;
    logic [3:0] wi_q, wi_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic pend_q, pend_d, fit_q, fit_d;
    logic in_ready_q, in_ready_d, blk_start_q, blk_start_d;
    logic digest_valid_q, digest_valid_d, busy_q, busy_d;
    logic [HASH_W-1:0] h_in_q, h_in_d, digest_q, digest_d;
    logic xfer, wr_en, len_ld;
    wr_sel_e wr_sel;
    logic [2:0] nb;
    logic [63:0] len64;

    assign xfer  = in_valid & in_ready_q;
    assign nb    = (in_nbytes > 3'd4 || (!in_last && in_nbytes == 3'd0)) ? 3'd4 : in_nbytes;
    assign len64 = 64'(length_q);

    // pend: the 0x80000000 word is still owed at wi; fit: the length words go in this block.
    always_comb begin
        state_d        = state_q;
        next_d         = next_q;
        wi_d           = wi_q;
        length_d       = length_q;
        pend_d         = pend_q;
        fit_d          = fit_q;
        h_in_d         = h_in_q;
        digest_d       = digest_q;
        busy_d         = busy_q;
        digest_valid_d = 1'b0;
        wr_en          = 1'b0;
        wr_sel         = WR_DATA;
        len_ld         = 1'b0;
        case (state_q)
            IDLE, FILL: if (xfer) begin
                wr_en    = 1'b1;
                wr_sel   = in_last ? WR_MERGE : WR_DATA;
                wi_d     = wi_q + 4'd1;
                length_d = (state_q == IDLE ? '0 : length_q) + LEN_W'({nb, 3'b000});
                state_d  = FILL;
                if (state_q == IDLE) begin
                    h_in_d = IV;
                    busy_d = 1'b1;
                end
                if (!in_last) begin
                    if (wi_q == 4'd15) begin
                        state_d = ISSUE;
                        next_d  = FILL;
                    end
                end else if (nb == 3'd4) begin
                    pend_d  = 1'b1;
                    state_d = wi_q == 4'd15 ? ISSUE : PAD;
                    next_d  = PAD;
                end else begin
                    pend_d  = 1'b0;
                    fit_d   = wi_q <= 4'd13;
                    state_d = wi_q == 4'd15 ? ISSUE : PAD;
                    next_d  = LEN;
                end
            end
            PAD: begin
                wr_en  = 1'b1;
                wr_sel = pend_q ? WR_PAD80 : !fit_q ? WR_ZERO :
                         wi_q == 4'd14 ? WR_LEN_HI : wi_q == 4'd15 ? WR_LEN_LO : WR_ZERO;
                pend_d = 1'b0;
                fit_d  = pend_q ? wi_q <= 4'd13 : fit_q;
                wi_d   = wi_q + 4'd1;
                if (wi_q == 4'd15) begin
                    state_d = ISSUE;
                    next_d  = (!pend_q && fit_q) ? FIN : LEN;
                end
            end
            LEN: begin
                len_ld  = 1'b1;
                state_d = ISSUE;
                next_d  = FIN;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (core_done) begin
                h_in_d  = h_out;
                wi_d    = '0;
                state_d = next_q;
            end
            FIN: begin
                digest_d       = h_in_q;
                digest_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE || state_d == FILL;
        blk_start_d = state_d == ISSUE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            next_q         <= IDLE;
            wi_q           <= '0;
            length_q       <= '0;
            pend_q         <= 1'b0;
            fit_q          <= 1'b0;
            h_in_q         <= IV;
            digest_q       <= '0;
            in_ready_q     <= 1'b0;
            blk_start_q    <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_q         <= next_d;
            wi_q           <= wi_d;
            length_q       <= length_d;
            pend_q         <= pend_d;
            fit_q          <= fit_d;
            h_in_q         <= h_in_d;
            digest_q       <= digest_d;
            in_ready_q     <= in_ready_d;
            blk_start_q    <= blk_start_d;
            digest_valid_q <= digest_valid_d;
            busy_q         <= busy_d;
        end
    end

    sha1_block_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wi_q),
        .wr_sel    (wr_sel),
        .wr_data   (in_data),
        .wr_nbytes (nb),
        .len_ld    (len_ld),
        .len       (len64),
        .blk       (blk)
    );

    assign in_ready     = in_ready_q;
    assign blk_start    = blk_start_q;
    assign h_in         = h_in_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_sha1_msg_sequencer.sv
// tb_sha1_msg_sequencer: byte-level padding/chaining model plus an 80-cycle behavioural SHA-1 core,
// checked every cycle against the sequencer and pinned by known SHA-1 digests.
module tb_sha1_msg_sequencer;
    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    typedef logic [7:0] bq_t[$];
    typedef struct {logic [511:0] blk; logic [159:0] h;} exp_t;

    logic clk, rst, in_valid, in_ready, in_last, blk_start, core_done, digest_valid, busy;
    logic [31:0] in_data;
    logic [2:0] in_nbytes;
    logic [511:0] blk;
    logic [159:0] h_in, h_out, digest;

    int tests = 0, fails = 0, cyc = 0, done_cyc = 0, dig_seen = 0;
    bit inflight = 0;
    exp_t exp_q[$];
    exp_t ex;
    logic [159:0] dig_q[$];
    logic [159:0] dig_hist[$];
    logic [511:0] cap_q[$];

    sha1_msg_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_nbytes(in_nbytes), .blk_start(blk_start), .blk(blk), .h_in(h_in),
        .core_done(core_done), .h_out(h_out), .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [159:0] sha1_compress(input logic [159:0] hv, input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = hv;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin f = (b & c) | (~b & d); k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d; k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else begin f = b ^ c ^ d; k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
        end
        return {hv[159:128] + a, hv[127:96] + b, hv[95:64] + c, hv[63:32] + d, hv[31:0] + e};
    endfunction

    // Behavioural compression core: result appears 80 cycles after blk_start.
    int core_cnt;
    logic core_busy;
    logic [159:0] core_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_busy <= 0; core_done <= 0; core_cnt <= 0; h_out <= '0; core_res <= '0;
        end else begin
            core_done <= 0;
            if (blk_start) begin
                core_busy <= 1; core_cnt <= 80; core_res <= sha1_compress(h_in, blk);
            end else if (core_busy) begin
                if (core_cnt == 1) begin core_done <= 1; core_busy <= 0; h_out <= core_res; end
                core_cnt <= core_cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic flag(input string nm, input string why);
        tests++;
        fails++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Standard SHA-1 padding at byte level, then chain the expected blocks and digest.
    task automatic model_msg(input bq_t m);
        bq_t p;
        logic [63:0] bits;
        logic [159:0] hv;
        logic [511:0] b;
        p = m;
        bits = 64'(m.size()) << 3;
        hv = IV;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        for (int k = 0; k < p.size() / 64; k++) begin
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
            exp_q.push_back('{blk: b, h: hv});
            hv = sha1_compress(hv, b);
        end
        dig_q.push_back(hv);
    endtask

    always @(negedge clk) begin
        if (rst) inflight = 0;
        else begin
            if (blk_start) begin
                cap_q.push_back(blk);
                chk("busy_at_issue", busy, 1);
                if (exp_q.size() == 0) flag("blk_unexpected", "blk_start with no block expected");
                else begin
                    ex = exp_q.pop_front();
                    chk("blk", blk, ex.blk);
                    chk("h_in", h_in, ex.h);
                end
                inflight = 1;
            end
            if (inflight) chk("in_ready_in_flight", in_ready, 0);
            if (core_done && inflight) begin inflight = 0; done_cyc = cyc; end
            if (digest_valid) begin
                dig_seen++;
                dig_hist.push_back(digest);
                chk("dv_latency", cyc - done_cyc, 2);
                chk("busy_at_dv", busy, 0);
                if (dig_q.size() == 0) flag("dv_unexpected", "digest_valid with no digest expected");
                else chk("digest", digest, dig_q.pop_front());
            end
        end
    end

    task automatic put_word(input logic [31:0] d, input int nb, input bit last);
        int c;
        bit acc;
        c = 0;
        in_valid = 1; in_data = d; in_nbytes = 3'(nb); in_last = last;
        forever begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
            if (++c > 3000) begin flag("word_timeout", "word not accepted in 3000 cycles"); break; end
        end
        in_valid = 0; in_last = 0;
    endtask

    task automatic send(input bq_t m, input bit gaps);
        int n, nw, nb;
        logic [31:0] d;
        n = m.size();
        nw = n == 0 ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            nb = n - 4 * w;
            if (nb > 4) nb = 4;
            d = '0;
            for (int j = 0; j < nb; j++) d[31-8*j -: 8] = m[4*w+j];
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            put_word(d, nb, w == nw - 1);
        end
    endtask

    task automatic wait_dig(input int target);
        int c;
        c = 0;
        while (dig_seen < target && c < 3000) begin @(negedge clk); c++; end
        if (dig_seen < target) flag("digest_timeout", "no digest_valid within 3000 cycles");
    endtask

    task automatic run_msg(input bq_t m, input bit gaps);
        int n0;
        cap_q.delete();
        model_msg(m);
        n0 = dig_seen;
        send(m, gaps);
        wait_dig(n0 + 1);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_blk_start", blk_start, 0);
        chk("rst_blk", blk, 0);
        chk("rst_h_in", h_in, IV);
        chk("rst_digest", digest, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_busy", busy, 0);
    endtask

    localparam logic [159:0] D_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_56 = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    initial begin
        bq_t m56, m64;
        logic [511:0] b;
        int n0, c;
        rst = 1; in_valid = 0; in_data = '0; in_nbytes = '0; in_last = 0;
        m56 = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        m64 = {};
        for (int i = 0; i < 64; i++) m64.push_back(8'h61);
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 0;
        @(negedge clk);

        run_msg(str2q("abc"), 0);
        chk("abc_digest", dig_hist[$], D_ABC);
        chk("abc_blocks", cap_q.size(), 1);
        b = cap_q[0];
        chk("abc_word0", b[511:480], 32'h61626380);
        chk("abc_word15", b[31:0], 32'h18);
        repeat (5) @(negedge clk);
        chk("digest_hold", digest, D_ABC);

        run_msg(str2q(""), 0);
        chk("empty_digest", dig_hist[$], D_EMPTY);
        b = cap_q[0];
        chk("empty_word0", b[511:480], 32'h80000000);
        chk("empty_word15", b[31:0], 32'h0);

        run_msg(m56, 0);
        chk("m56_digest", dig_hist[$], D_56);
        chk("m56_blocks", cap_q.size(), 2);
        b = cap_q[0];
        chk("m56_b0_word14", b[63:32], 32'h80000000);
        b = cap_q[1];
        chk("m56_b1_word15", b[31:0], 32'h1c0);

        cap_q.delete();
        model_msg(str2q("abc"));
        model_msg(str2q("abc"));
        n0 = dig_seen;
        send(str2q("abc"), 1);
        send(str2q("abc"), 1);
        wait_dig(n0 + 2);
        chk("b2b_first", dig_hist[$-1], D_ABC);
        chk("b2b_second", dig_hist[$], D_ABC);
        chk("b2b_blocks", cap_q.size(), 2);

        cap_q.delete();
        model_msg(m56);
        send(m56, 0);
        c = 0;
        while (cap_q.size() < 1 && c < 3000) begin @(negedge clk); c++; end
        if (cap_q.size() < 1) flag("issue_timeout", "no blk_start before reset test");
        repeat (10) @(negedge clk);
        rst = 1;
        exp_q.delete();
        dig_q.delete();
        @(negedge clk);
        chk_reset();
        rst = 0;
        n0 = dig_seen;
        repeat (200) @(negedge clk);
        chk("no_stale_dv", dig_seen, n0);
        run_msg(str2q("abc"), 0);
        chk("post_rst_digest", dig_hist[$], D_ABC);

        run_msg(m64, 0);
        chk("m64_blocks", cap_q.size(), 2);
        b = cap_q[1];
        chk("m64_b1_word0", b[511:480], 32'h80000000);
        chk("m64_b1_word15", b[31:0], 32'h200);
        chk("model_queue_drained", exp_q.size() + dig_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        flag("watchdog", "simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
